// File: rtl/taxi_eth_mac_pfc_tx_ctrl.sv
// PFC transmit request engine: per-class pause levels -> PFC frame descriptors (XOFF/XON/refresh/resend).
// Latency: request edge to m_mcf_valid is 2 cycles from IDLE; stat pulses appear the cycle after accept.
// Backpressure: descriptor held stable while m_mcf_ready is low; new events accumulate in pending.
module taxi_eth_mac_pfc_tx_ctrl #(
    parameter int PRIO_CNT = 8,
    parameter int DATA_W   = 64,
    parameter int QUANTA_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PRIO_CNT-1:0]          tx_pfc_req,
    input  logic                         tx_pfc_resend,
    input  logic                         cfg_pfc_en,
    input  logic [PRIO_CNT*QUANTA_W-1:0] cfg_quanta,
    input  logic [PRIO_CNT*QUANTA_W-1:0] cfg_refresh,
    output logic                         m_mcf_valid,
    input  logic                         m_mcf_ready,
    output logic [7:0]                   m_mcf_class_en,
    output logic [8*QUANTA_W-1:0]        m_mcf_quanta,
    output logic [PRIO_CNT-1:0]          pfc_active,
    output logic                         stat_pfc_pkt,
    output logic [PRIO_CNT-1:0]          stat_pfc_xon,
    output logic [PRIO_CNT-1:0]          stat_pfc_xoff
);
    localparam int PRE_CNT = 512 / DATA_W;
    localparam int PRE_W   = PRE_CNT > 1 ? $clog2(PRE_CNT) : 1;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state_reg, state_next;

    logic [PRIO_CNT-1:0] req_q, req_q_d;
    logic [PRIO_CNT-1:0] pending_reg, pending_next;
    logic [PRIO_CNT-1:0] event_vec, expire_vec;
    logic [PRIO_CNT-1:0] timer_clr, timer_load;
    logic [PRIO_CNT-1:0] sent_req_reg;
    logic [QUANTA_W-1:0] timer_reg [PRIO_CNT];
    logic [8*QUANTA_W-1:0] quanta_launch;
    logic [PRE_W-1:0] pre_reg;
    logic tick, launch, accept;

    // With a single-cycle quantum the prescaler sits at 0 and ticks every cycle.
    assign tick        = (pre_reg == PRE_W'(PRE_CNT - 1));
    assign m_mcf_valid = (state_reg == SEND);
    assign pfc_active  = req_q;

    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pending_reg != '0 && cfg_pfc_en) begin
                    launch     = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (m_mcf_ready) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Timer priority: clear, then reload on launch, then decrement; expiry only on a real 1->0 step.
    always_comb begin
        timer_clr     = '0;
        timer_load    = '0;
        expire_vec    = '0;
        quanta_launch = '0;
        for (int i = 0; i < PRIO_CNT; i++) begin
            timer_clr[i]  = !cfg_pfc_en || !req_q[i] || (cfg_refresh[i*QUANTA_W +: QUANTA_W] == '0);
            timer_load[i] = launch && pending_reg[i];
            expire_vec[i] = !timer_clr[i] && !timer_load[i] && tick &&
                            (timer_reg[i] == QUANTA_W'(1));
            quanta_launch[i*QUANTA_W +: QUANTA_W] = req_q[i] ? cfg_quanta[i*QUANTA_W +: QUANTA_W] : '0;
        end
    end

    always_comb begin
        event_vec    = (req_q ^ req_q_d) | (req_q & (expire_vec | {PRIO_CNT{tx_pfc_resend}}));
        pending_next = cfg_pfc_en ? ((launch ? '0 : pending_reg) | event_vec) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PRIO_CNT; i++) begin
                timer_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PRIO_CNT; i++) begin
                if (timer_clr[i]) begin
                    timer_reg[i] <= '0;
                end else if (timer_load[i]) begin
                    timer_reg[i] <= cfg_refresh[i*QUANTA_W +: QUANTA_W];
                end else if (tick && timer_reg[i] != '0) begin
                    timer_reg[i] <= timer_reg[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            req_q          <= '0;
            req_q_d        <= '0;
            pending_reg    <= '0;
            sent_req_reg   <= '0;
            pre_reg        <= '0;
            m_mcf_class_en <= '0;
            m_mcf_quanta   <= '0;
            stat_pfc_pkt   <= 1'b0;
            stat_pfc_xon   <= '0;
            stat_pfc_xoff  <= '0;
        end else begin
            state_reg   <= state_next;
            req_q       <= tx_pfc_req & {PRIO_CNT{cfg_pfc_en}};
            req_q_d     <= req_q;
            pending_reg <= pending_next;
            pre_reg     <= tick ? '0 : pre_reg + 1'b1;
            if (launch) begin
                m_mcf_class_en <= 8'(pending_reg);
                m_mcf_quanta   <= quanta_launch;
                sent_req_reg   <= req_q;
            end
            stat_pfc_pkt  <= accept;
            stat_pfc_xoff <= accept ? (m_mcf_class_en[PRIO_CNT-1:0] & sent_req_reg) : '0;
            stat_pfc_xon  <= accept ? (m_mcf_class_en[PRIO_CNT-1:0] & ~sent_req_reg) : '0;
        end
    end

endmodule

// File: doc/taxi_eth_mac_pfc_tx_ctrl.md
Name: taxi_eth_mac_pfc_tx_ctrl

Overview:
Parametrised transmit-side priority flow control (802.3 annex 31D) request engine for the taxi Ethernet MACs.
- Class count is configurable (1..8, no longer fixed at 8); quanta tick rate is derived from the datapath width (32..512 bits).
- Converts per-class level pause requests into PFC frame descriptors: XOFF on assert, XON on deassert, periodic refresh while asserted, forced resend.
- Hands descriptors to the MAC control-frame generator over a valid/ready handshake.

Parameters:
- PRIO_CNT, 8, number of priority classes (1..8); class i maps to PFC class_enable bit i.
- DATA_W, 64, MAC datapath width; one pause quantum (512 bit times) = 512/DATA_W cycles. Legal values: 32, 64, 128, 256, 512.
- QUANTA_W, 16, width of quanta and refresh fields.

Ports:
- clk  in  1  MAC clock
- rst  in  1  asynchronous active-high reset
- tx_pfc_req  in  PRIO_CNT  per-class pause request (level)
- tx_pfc_resend  in  1  pulse: resend state of all currently requested classes
- cfg_pfc_en  in  1  PFC transmit enable
- cfg_quanta  in  PRIO_CNT*QUANTA_W  per-class XOFF quanta
- cfg_refresh  in  PRIO_CNT*QUANTA_W  per-class refresh interval in quanta (0 = no refresh)
- m_mcf_valid  out  1  descriptor valid
- m_mcf_ready  in  1  generator accepts descriptor
- m_mcf_class_en  out  8  class_enable vector (bits >= PRIO_CNT always 0)
- m_mcf_quanta  out  8*QUANTA_W  per-class time field (class i at [i*QUANTA_W +: QUANTA_W])
- pfc_active  out  PRIO_CNT  registered effective request
- stat_pfc_pkt  out  1  pulse on descriptor accept
- stat_pfc_xon  out  PRIO_CNT  pulse, class sent as XON
- stat_pfc_xoff  out  PRIO_CNT  pulse, class sent as XOFF

Behaviour:
- Reset: all outputs 0; pending, timers, prescaler, req_q cleared; FSM in IDLE.
- Effective request eff[i] = tx_pfc_req[i] & cfg_pfc_en.
  - Registered into req_q each cycle; pfc_active = req_q.
  - req_q_d holds the previous value of req_q.
- Event for class i (any one sets pending[i]):
  - req_q[i] != req_q_d[i]
  - refresh timer expiry with req_q[i]=1
  - tx_pfc_resend with req_q[i]=1
- Prescaler: free-running, wraps at 512/DATA_W-1. tick = prescaler at wrap; for DATA_W=512, tick every cycle.
- Refresh timer per class:
  - Loaded with cfg_refresh[i] when class i is launched with req=1.
  - Decrements on tick while nonzero and req_q[i]=1.
  - Expiry = transition 1->0.
  - Cleared when req_q[i]=0 or cfg_refresh[i]=0.
- FSM IDLE:
  - If pending!=0 and cfg_pfc_en=1, launch:
    - class_en[i] = pending[i]
    - quanta[i] = req_q[i] ? cfg_quanta[i] : 0
    - pending cleared, m_mcf_valid=1, go to SEND.
  - Events in the launch cycle set pending for the next frame.
- FSM SEND:
  - Outputs held stable until m_mcf_valid & m_mcf_ready, then return to IDLE.
  - Next launch earliest one cycle later.
  - Events during SEND accumulate in pending.
- Handshake: m_mcf_valid never drops without ready. cfg_pfc_en deassert mid-SEND does not abort the frame.
- Stats: on accept, for one cycle:
  - stat_pfc_pkt=1
  - stat_pfc_xoff[i] = class_en[i] & quanta nonzero-request (req at launch)
  - stat_pfc_xon[i] = class_en[i] & !req at launch
- Latency: a req change sampled at edge 0 sets pending at edge 1; m_mcf_valid is high after edge 2 when IDLE.
- cfg_pfc_en=0:
  - pending and timers cleared every cycle; no launches.
  - The resulting eff falling edge produces no XON frame.
  - Re-enable with req high produces XOFF.
- Simultaneous edge + resend + expiry on one class: a single pending bit, so exactly one frame entry.
- Reset mid-SEND: valid drops immediately (async); no stat pulse.

Test Plan:
1. DATA_W=64, quanta[2]=0xFFFF, refresh[2]=4. Raise req[2], ready=1 -> valid after 2 cycles, class_en=0x04, quanta[2]=0xFFFF, stat_pfc_xoff=0x04; refresh frame repeats every 32 cycles.
2. Drop req[2] -> frame with class_en=0x04, quanta[2]=0, stat_pfc_xon=0x04; no further refresh frames.
3. ready=0 for 10 cycles while raising req[0], then req[5] -> first frame holds class_en=0x01 stable all 10 cycles; second frame class_en=0x20.
4. Raise req[1] and req[3] in the same cycle -> single frame, class_en=0x0A; pulse tx_pfc_resend -> one frame, class_en=0x0A.
5. PRIO_CNT=3, DATA_W=512, refresh[0]=2 -> refresh every 2 cycles after accept; class_en bits 7:3 always 0.
6. cfg_pfc_en=0 with req=0x01 -> no frames, pfc_active=0. Enable -> XOFF frame. Assert rst during SEND -> valid=0 immediately, no stat pulse.
